button_conditioner: RTL and testbench

- Input-side front end for the Nibbler processor's 4-bit `pushbuttons` port, which the IN instruction samples.
- Per bit it synchronises the raw asynchronous switch inputs, debounces them with a stability counter, and generates single-cycle press events.
- It optionally presents sticky (latched-until-acknowledged) press bits instead of the live level, so a short press is not lost between IN instructions.
- Sits between board pins and the processor's `pushbuttons` input, clocked by the processor clock.

---
 rtl/button_conditioner.sv | 75 +++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end for the Nibbler IN port: two-flop synchroniser, per-bit
// symmetric stability debounce, one-cycle press pulses and sticky press capture.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] buttons_raw,
   input  logic       sticky_mode,
   input  logic [3:0] ack,
   output logic [3:0] pushbuttons,
   output logic [3:0] press_event,
   output logic       any_pressed
);

   localparam int unsigned N_BTN = 4;
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync1_q, sync1_d;
   logic [N_BTN-1:0] sync2_q, sync2_d;
   logic [N_BTN-1:0] stable_q, stable_d;
   logic [N_BTN-1:0] press_q, press_d;
   logic [N_BTN-1:0] sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];

   // Next-state: a level is accepted only after CNT_MAX+1 consecutive mismatching samples.
   always_comb begin
      sync1_d  = buttons_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      press_d  = stable_d & ~stable_q;
      // A new press beats a simultaneous acknowledge.
      sticky_d = press_d | (sticky_q & ~ack);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         press_q  <= '0;
         sticky_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         sticky_q <= sticky_d;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pushbuttons = sticky_mode ? sticky_q : stable_q;
   assign press_event = press_q;
   assign any_pressed = |stable_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner: expected press pulses are queued
// with their due cycle when stimulus is driven and popped by a per-cycle monitor.
module tb_button_conditioner;

   localparam int unsigned DB  = 4;
   localparam int          LAT = DB + 2;

   logic       clock;
   logic       reset;
   logic [3:0] buttons_raw;
   logic       sticky_mode;
   logic [3:0] ack;
   logic [3:0] pushbuttons;
   logic [3:0] press_event;
   logic       any_pressed;

   typedef struct {
      int         cyc;
      logic [3:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock       (clock),
      .reset       (reset),
      .buttons_raw (buttons_raw),
      .sticky_mode (sticky_mode),
      .ack         (ack),
      .pushbuttons (pushbuttons),
      .press_event (press_event),
      .any_pressed (any_pressed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Raw change driven now is first sampled at edge cyc+1; the pulse follows LAT edges on.
   task automatic expect_press(input logic [3:0] bits);
      exp_t e;
      e.cyc = cyc + LAT;
      e.val = bits;
      exp_q.push_back(e);
   endtask

   // Monitor: press_event must equal the queued value on its due cycle and zero otherwise.
   always @(negedge clock) begin
      logic [3:0] e;
      e = 4'b0000;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q[0].val;
         void'(exp_q.pop_front());
      end
      check("press_event", 32'(press_event), 32'(e));
   end

   initial begin
      reset       = 1'b1;
      buttons_raw = 4'b0000;
      sticky_mode = 1'b0;
      ack         = 4'b0000;
      tick(3);
      check("rst_pushbuttons", 32'(pushbuttons), 32'h0);
      check("rst_any", 32'(any_pressed), 32'h0);
      reset = 1'b0;

      // Idle
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("idle_pushbuttons", 32'(pushbuttons), 32'h0);
         check("idle_any", 32'(any_pressed), 32'h0);
      end

      // Clean press of bit 0, latency boundary
      buttons_raw = 4'b0001;
      expect_press(4'b0001);
      tick(LAT - 1);
      check("b0_before_accept", 32'(pushbuttons), 32'h0);
      tick(1);
      check("b0_accept", 32'(pushbuttons), 32'h1);
      check("b0_any", 32'(any_pressed), 32'h1);
      buttons_raw = 4'b0000;
      tick(LAT - 1);
      check("b0_release_pending", 32'(pushbuttons), 32'h1);
      tick(1);
      check("b0_released", 32'(pushbuttons), 32'h0);
      check("b0_release_any", 32'(any_pressed), 32'h0);

      // Bouncing bit 2 then settle high
      for (int i = 0; i < 8; i++) begin
         buttons_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
         tick(1);
         check("bounce_stable", 32'(pushbuttons), 32'h0);
      end
      buttons_raw = 4'b0100;
      expect_press(4'b0100);
      tick(LAT + 2);
      check("bounce_accept", 32'(pushbuttons), 32'h4);
      buttons_raw = 4'b0000;
      tick(LAT + 2);
      check("bounce_release", 32'(pushbuttons), 32'h0);

      // Sticky bits accumulated while in level mode
      sticky_mode = 1'b1;
      #1;
      check("sticky_accum", 32'(pushbuttons), 32'h5);
      ack = 4'b1111;
      tick(1);
      ack = 4'b0000;
      check("sticky_ack_all", 32'(pushbuttons), 32'h0);

      // Sticky press of bit 3 survives release
      buttons_raw = 4'b1000;
      expect_press(4'b1000);
      tick(6);
      buttons_raw = 4'b0000;
      tick(10);
      check("sticky_hold", 32'(pushbuttons), 32'h8);
      sticky_mode = 1'b0;
      #1;
      check("sticky_live_view", 32'(pushbuttons), 32'h0);
      sticky_mode = 1'b1;
      #1;
      check("sticky_kept", 32'(pushbuttons), 32'h8);
      ack = 4'b1000;
      tick(1);
      ack = 4'b0000;
      check("sticky_acked", 32'(pushbuttons), 32'h0);

      // Held ack with a new press: set wins, then ack clears
      buttons_raw = 4'b1000;
      expect_press(4'b1000);
      ack = 4'b1000;
      tick(LAT);
      check("set_beats_ack", 32'(pushbuttons), 32'h8);
      tick(1);
      check("ack_clears_after", 32'(pushbuttons), 32'h0);
      ack = 4'b0000;
      buttons_raw = 4'b0000;
      tick(LAT + 2);

      // Bits 0 and 1 pressed together, short vs long hold
      sticky_mode = 1'b0;
      buttons_raw = 4'b0011;
      expect_press(4'b0010);
      tick(3);
      buttons_raw = 4'b0010;
      tick(4);
      buttons_raw = 4'b0000;
      check("dual_level", 32'(pushbuttons), 32'h2);
      tick(LAT + 2);
      check("dual_released", 32'(pushbuttons), 32'h0);
      sticky_mode = 1'b1;
      #1;
      check("dual_sticky", 32'(pushbuttons), 32'h2);
      sticky_mode = 1'b0;

      // Reset asserted mid-cycle while a pulse is high
      buttons_raw = 4'b0100;
      expect_press(4'b0100);
      tick(LAT);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_event", 32'(press_event), 32'h0);
      check("midrst_level", 32'(pushbuttons), 32'h0);
      check("midrst_any", 32'(any_pressed), 32'h0);
      sticky_mode = 1'b1;
      #1;
      check("midrst_sticky", 32'(pushbuttons), 32'h0);
      sticky_mode = 1'b0;
      buttons_raw = 4'b0000;
      tick(2);
      reset = 1'b0;
      tick(3);

      // Reset at debounce count 2 with the button held
      buttons_raw = 4'b0001;
      tick(4);
      reset = 1'b1;
      tick(2);
      check("cnt2_rst_level", 32'(pushbuttons), 32'h0);
      reset = 1'b0;
      expect_press(4'b0001);
      tick(LAT - 1);
      check("cnt2_before", 32'(pushbuttons), 32'h0);
      tick(1);
      check("cnt2_accept", 32'(pushbuttons), 32'h1);
      buttons_raw = 4'b0000;
      tick(LAT + 4);

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
